// File: rtl/fl_pkg.sv
// fl_pkg: shared types and constants for the free-list controller
package fl_pkg;
  localparam int FL_WIDTH = 7;
  localparam int FL_INDEX = 7;
  localparam int ARCH_REGS = 32;
  typedef logic [FL_WIDTH-1:0] phys_tag_t;
  typedef logic [FL_INDEX-1:0] fl_idx_t;
  typedef enum logic {FL_INIT, FL_RUN} fl_state_t;
endpackage

// File: rtl/fl_wrap_add.sv
// fl_wrap_add: (ptr + off) modulo the active free-list depth
module fl_wrap_add
  import fl_pkg::*;
(
  input  fl_idx_t             ptr,
  input  fl_idx_t             off,
  input  logic [FL_INDEX:0]   depth,
  output fl_idx_t             sum
);
  logic [FL_INDEX:0] raw;
  // ptr < depth and off <= depth, so one conditional subtraction wraps it
  assign raw = {1'b0, ptr} + {1'b0, off};
  assign sum = fl_idx_t'(raw >= depth ? raw - depth : raw);
endmodule

// File: rtl/free_list_ctrl.sv
// free_list_ctrl: head/tail controller for the circular free-tag RAM
module free_list_ctrl
  import fl_pkg::*;
#(
  parameter int DISPATCH_WIDTH = 4,
  parameter int COMMIT_WIDTH   = 4,
  parameter int DEPTH          = 96,
  parameter int INDEX          = FL_INDEX,
  parameter int WIDTH          = FL_WIDTH,
  parameter int NUM_PARTS      = 4
)(
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PARTS-1:0]            flPartitionActive_i,
  input  logic [DISPATCH_WIDTH-1:0]       allocReq_i,
  output logic                            allocStall_o,
  output logic [DISPATCH_WIDTH*WIDTH-1:0] allocTag_o,
  output logic [DISPATCH_WIDTH*INDEX-1:0] rdAddr_o,
  input  logic [DISPATCH_WIDTH*WIDTH-1:0] rdData_i,
  input  logic [COMMIT_WIDTH-1:0]         releaseValid_i,
  input  logic [COMMIT_WIDTH*WIDTH-1:0]   releaseTag_i,
  output logic [COMMIT_WIDTH-1:0]         we_o,
  output logic [COMMIT_WIDTH*INDEX-1:0]   wrAddr_o,
  output logic [COMMIT_WIDTH*WIDTH-1:0]   wrData_o,
  input  logic                            recover_i,
  output logic [INDEX:0]                  freeCount_o,
  output logic                            ready_o,
  output logic                            overflow_o
);
  localparam int NW = $clog2(DISPATCH_WIDTH + 1);
  localparam int MW = $clog2(COMMIT_WIDTH + 1);
  localparam int CW1 = INDEX + 1;
  fl_state_t state, state_next;
  logic [INDEX-1:0] head, tail, ptr, head_next, tail_next;
  logic [CW1-1:0] count, active_depth, depth_cfg, parts, sum;
  logic [NW-1:0] n, grant;
  logic [MW-1:0] m, m_eff;
  logic [MW-1:0] pfx [COMMIT_WIDTH];
  logic [INDEX-1:0] rd_lane [DISPATCH_WIDTH+1];
  logic [INDEX-1:0] wr_slot [COMMIT_WIDTH+1];
  phys_tag_t slot_tag [COMMIT_WIDTH];
  logic init_done, drop, stall;
  // Lane k of each array is base+k wrapped; the extra top lane serves pointer advance
  for (genvar i = 0; i <= DISPATCH_WIDTH; i++) begin : g_rd
    fl_wrap_add u_rd (.ptr(head), .off(fl_idx_t'(i)), .depth(active_depth), .sum(rd_lane[i]));
  end
  for (genvar i = 0; i <= COMMIT_WIDTH; i++) begin : g_wr
    fl_wrap_add u_wr (.ptr(tail), .off(fl_idx_t'(i)), .depth(active_depth), .sum(wr_slot[i]));
  end
  // Population counts: requests, releases (with per-lane prefix), active partitions
  always_comb begin
    n = '0;
    m = '0;
    parts = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) n += NW'(allocReq_i[i]);
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      pfx[i] = m;
      m += MW'(releaseValid_i[i]);
    end
    for (int i = 0; i < NUM_PARTS; i++) parts += CW1'(flPartitionActive_i[i]);
    depth_cfg = parts * CW1'(DEPTH / NUM_PARTS);
  end
  // Compact sparse release lanes into consecutive write slots
  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      slot_tag[k] = '0;
      for (int j = 0; j < COMMIT_WIDTH; j++)
        if (releaseValid_i[j] && pfx[j] == MW'(k)) slot_tag[k] = releaseTag_i[j*WIDTH +: WIDTH];
    end
  end
  // Grant/stall, overflow detection and pointer advance
  always_comb begin
    stall = reset | !ready_o | recover_i | (CW1'(n) > count);
    grant = stall ? '0 : n;
    sum = count + CW1'(m) - CW1'(grant);
    drop = ready_o & (sum > active_depth);
    m_eff = drop ? '0 : m;
    head_next = rd_lane[grant];
    tail_next = wr_slot[m_eff];
    init_done = CW1'(ptr) + CW1'(COMMIT_WIDTH) >= active_depth;
    state_next = (state == FL_INIT && init_done) ? FL_RUN : state;
  end
  // RAM port drive: init fill sequence, otherwise compacted releases at tail
  always_comb begin
    we_o = '0;
    wrAddr_o = '0;
    wrData_o = '0;
    rdAddr_o = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) rdAddr_o[k*INDEX +: INDEX] = rd_lane[k];
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      wrAddr_o[k*INDEX +: INDEX] = !ready_o ? ptr + INDEX'(k) : wr_slot[k];
      wrData_o[k*WIDTH +: WIDTH] = !ready_o ? WIDTH'(ARCH_REGS + int'(ptr) + k) : slot_tag[k];
      we_o[k] = !reset & (!ready_o ? (CW1'(ptr) + CW1'(k) < active_depth) : (!drop && MW'(k) < m));
    end
  end
  assign allocStall_o = stall;
  assign allocTag_o = rdData_i;
  assign freeCount_o = count;
  assign ready_o = state == FL_RUN;
  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= FL_INIT;
    else state <= state_next;
  end
  // Pointers, count, sticky overflow and sampled depth
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      overflow_o <= 1'b0;
      active_depth <= depth_cfg;
    end else if (state == FL_INIT) begin
      ptr <= ptr + INDEX'(COMMIT_WIDTH);
      if (init_done) count <= active_depth;
    end else begin
      tail <= tail_next;
      head <= recover_i ? tail_next : head_next;
      count <= recover_i ? active_depth : (drop ? count - CW1'(grant) : sum);
      overflow_o <= overflow_o | drop;
    end
  end
endmodule
